// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the clk_div_ctrl programmable clock divider.
package clk_div_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PEND  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

   localparam int MIN_DIV = 2;
   localparam int PCNT_W  = 16;

endpackage

// File: rtl/clk_div_phase.sv
// Phase counter for clk_div_ctrl: counts 0..div-1, registers the divided clock
// and flags the last cycle of each period.
module clk_div_phase #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst,
   input  logic             active_i,
   input  logic             active_nxt_i,
   input  logic [CNT_W-1:0] div_i,
   input  logic [CNT_W-1:0] div_nxt_i,
   output logic             clk_o,
   output logic             tick_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             clk_q;
   logic             clk_d;
   logic             last_w;

   assign last_w = (cnt_q == (div_i - CNT_W'(1)));

   // clk_o is computed from next-cycle count and ratio so that the registered
   // value lines up with the count it describes.
   always_comb begin
      cnt_d = '0;
      if (active_nxt_i && active_i && !last_w) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      clk_d = active_nxt_i && (cnt_d < (div_nxt_i >> 1));
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         cnt_q <= '0;
         clk_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         clk_q <= clk_d;
      end
   end

   assign clk_o  = clk_q;
   assign tick_o = active_i && last_w;

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider controller with boundary-aligned ratio changes.
// Optional tick counter output enabled by macro CLK_DIV_CTRL_PCNT_EN.
module clk_div_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int DIV_DEFAULT = 10
) (
   input  logic             clk_i,
   input  logic             rst,
   input  logic             run_i,
   input  logic             cfg_valid_i,
   input  logic [CNT_W-1:0] cfg_div_i,
   output logic             cfg_ready_o,
   output logic             clk_o,
   output logic             tick_o,
   output logic             busy_o,
   output logic             err_o
`ifdef CLK_DIV_CTRL_PCNT_EN
   ,
   output logic [PCNT_W-1:0] period_cnt_o
`endif
);

   generate
      if (DIV_DEFAULT < MIN_DIV) begin : g_bad_default
         $error("clk_div_ctrl: DIV_DEFAULT must be at least 2");
      end
   endgenerate

   state_e           state_q;
   state_e           state_d;
   logic [CNT_W-1:0] div_q;
   logic [CNT_W-1:0] div_d;
   logic [CNT_W-1:0] shadow_q;
   logic [CNT_W-1:0] shadow_d;
   logic             pend_q;
   logic             pend_d;
   logic             err_q;
   logic             err_d;
   logic             xfer_w;
   logic             legal_w;
   logic             tick_w;
   logic             active_q;
   logic             active_d;

   assign xfer_w   = cfg_valid_i && cfg_ready_o;
   assign legal_w  = (cfg_div_i >= CNT_W'(MIN_DIV));
   assign active_q = (state_q != ST_IDLE);
   assign active_d = (state_d != ST_IDLE);

   always_ff @(posedge clk_i) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A stop request always finishes the running period via DRAIN, even if
   // run_i comes back before the period ends.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (run_i) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (!run_i) state_d = ST_DRAIN;
            else if (xfer_w && legal_w && !tick_w) state_d = ST_PEND;
         end
         ST_PEND: begin
            if (!run_i) state_d = ST_DRAIN;
            else if (tick_w) state_d = ST_RUN;
         end
         ST_DRAIN: begin
            if (tick_w) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cfg_ready_o = 1'b0;
      busy_o      = 1'b1;
      case (state_q)
         ST_IDLE: begin
            cfg_ready_o = 1'b1;
            busy_o      = 1'b0;
         end
         ST_RUN:  cfg_ready_o = 1'b1;
         default: cfg_ready_o = 1'b0;
      endcase
   end

   // Ratio changes only land on a period boundary (or while idle), so no
   // clk_o phase is ever cut short.
   always_comb begin
      div_d    = div_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      err_d    = err_q;
      if (xfer_w && !legal_w) err_d = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (xfer_w && legal_w) div_d = cfg_div_i;
         end
         ST_RUN: begin
            if (xfer_w && legal_w) begin
               if (tick_w) begin
                  div_d = cfg_div_i;
               end else begin
                  shadow_d = cfg_div_i;
                  pend_d   = 1'b1;
               end
            end
         end
         default: begin
            if (tick_w && pend_q) begin
               div_d  = shadow_q;
               pend_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst) begin
         div_q    <= CNT_W'(DIV_DEFAULT);
         shadow_q <= CNT_W'(DIV_DEFAULT);
         pend_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         div_q    <= div_d;
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
      end
   end

   assign err_o  = err_q;
   assign tick_o = tick_w;

   clk_div_phase #(
      .CNT_W(CNT_W)
   ) u_phase (
      .clk_i        (clk_i),
      .rst          (rst),
      .active_i     (active_q),
      .active_nxt_i (active_d),
      .div_i        (div_q),
      .div_nxt_i    (div_d),
      .clk_o        (clk_o),
      .tick_o       (tick_w)
   );

`ifdef CLK_DIV_CTRL_PCNT_EN
   logic [PCNT_W-1:0] pcnt_q;
   logic [PCNT_W-1:0] pcnt_d;

   assign pcnt_d = tick_w ? (pcnt_q + PCNT_W'(1)) : pcnt_q;

   always_ff @(posedge clk_i) begin
      if (rst) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

   assign period_cnt_o = pcnt_q;
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: ratio handshake, PEND/DRAIN paths, errors, reset.
module tb_clk_div_ctrl;

   logic        clk;
   logic        rst;
   logic        run;
   logic        cfg_valid;
   logic [31:0] cfg_div;
   logic        cfg_ready;
   logic        clk_o;
   logic        tick_o;
   logic        busy;
   logic        err;
`ifdef CLK_DIV_CTRL_PCNT_EN
   logic [15:0] period_cnt;
   logic [15:0] exp_pcnt;
`endif

   int checks = 0;
   int errors = 0;

   clk_div_ctrl #(
      .CNT_W(32),
      .DIV_DEFAULT(10)
   ) dut (
      .clk_i        (clk),
      .rst          (rst),
      .run_i        (run),
      .cfg_valid_i  (cfg_valid),
      .cfg_div_i    (cfg_div),
      .cfg_ready_o  (cfg_ready),
      .clk_o        (clk_o),
      .tick_o       (tick_o),
      .busy_o       (busy),
      .err_o        (err)
`ifdef CLK_DIV_CTRL_PCNT_EN
      ,
      .period_cnt_o (period_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks n consecutive cycles of a period of length div starting at phase start.
   task automatic run_cycles(input string tag, input int div, input int start, input int n);
      int c;
      for (int i = 0; i < n; i++) begin
         c = (start + i) % div;
         check({tag, "_clk"},  32'(clk_o),  32'(c < div / 2));
         check({tag, "_tick"}, 32'(tick_o), 32'(c == div - 1));
         check({tag, "_busy"}, 32'(busy),   32'd1);
`ifdef CLK_DIV_CTRL_PCNT_EN
         if (c == div - 1) exp_pcnt++;
`endif
         step();
      end
   endtask

   initial begin
      rst       = 1'b1;
      run       = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = '0;
`ifdef CLK_DIV_CTRL_PCNT_EN
      exp_pcnt  = '0;
`endif
      step();
      step();
      check("rst_clk",   32'(clk_o),     32'd0);
      check("rst_tick",  32'(tick_o),    32'd0);
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_ready", 32'(cfg_ready), 32'd1);
      check("rst_err",   32'(err),       32'd0);
      rst = 1'b0;
      step();
      check("idle_ready", 32'(cfg_ready), 32'd1);
      check("idle_busy",  32'(busy),      32'd0);

      // illegal ratio while idle
      cfg_valid = 1'b1;
      cfg_div   = 32'd1;
      step();
      cfg_valid = 1'b0;
      check("bad_idle_err",  32'(err),  32'd1);
      check("bad_idle_busy", 32'(busy), 32'd0);
      step();
      step();
      check("err_sticky", 32'(err), 32'd1);

      // default ratio 10: 5 high / 5 low
      run = 1'b1;
      step();
      run_cycles("div10", 10, 0, 20);
      check("run_ready", 32'(cfg_ready), 32'd1);

      // ratio 4 offered on the boundary: loads directly
      run_cycles("pre4", 10, 0, 9);
      cfg_valid = 1'b1;
      cfg_div   = 32'd4;
      check("at9_ready", 32'(cfg_ready), 32'd1);
      run_cycles("at9", 10, 9, 1);
      cfg_valid = 1'b0;
      check("no_pend_ready", 32'(cfg_ready), 32'd1);
      run_cycles("div4", 4, 0, 8);
      run_cycles("div4b", 4, 0, 3);
      cfg_valid = 1'b1;
      cfg_div   = 32'd10;
      run_cycles("to10", 4, 3, 1);
      cfg_valid = 1'b0;

      // ratio 7 offered mid-period: waits in PEND
      run_cycles("c10", 10, 0, 3);
      cfg_valid = 1'b1;
      cfg_div   = 32'd7;
      check("off7_ready", 32'(cfg_ready), 32'd1);
      run_cycles("off7", 10, 3, 1);
      cfg_valid = 1'b0;
      check("pend_ready", 32'(cfg_ready), 32'd0);
      run_cycles("pend", 10, 4, 6);
      check("pend_done_ready", 32'(cfg_ready), 32'd1);
      run_cycles("div7", 7, 0, 14);

      run_cycles("c7", 7, 0, 6);
      cfg_valid = 1'b1;
      cfg_div   = 32'd10;
      run_cycles("to10b", 7, 6, 1);
      cfg_valid = 1'b0;

      // stop with ratio 6 pending, run_i returns during drain
      run_cycles("d10", 10, 0, 1);
      cfg_valid = 1'b1;
      cfg_div   = 32'd6;
      run_cycles("off6", 10, 1, 1);
      cfg_valid = 1'b0;
      check("pend6_ready", 32'(cfg_ready), 32'd0);
      run = 1'b0;
      run_cycles("drop", 10, 2, 1);
      check("drain_ready", 32'(cfg_ready), 32'd0);
      run_cycles("drain", 10, 3, 2);
      run = 1'b1;
      run_cycles("drain_rerun", 10, 5, 5);
      check("post_drain_clk",   32'(clk_o),     32'd0);
      check("post_drain_tick",  32'(tick_o),    32'd0);
      check("post_drain_busy",  32'(busy),      32'd0);
      check("post_drain_ready", 32'(cfg_ready), 32'd1);
      step();
      run_cycles("div6", 6, 0, 12);
`ifdef CLK_DIV_CTRL_PCNT_EN
      check("pcnt_run", 32'(period_cnt), 32'(exp_pcnt));
`endif

      // reset mid-period
      run_cycles("c6", 6, 0, 3);
      check("pre_rst_err", 32'(err), 32'd1);
      rst = 1'b1;
      run = 1'b0;
      step();
      check("mid_rst_clk",   32'(clk_o),     32'd0);
      check("mid_rst_tick",  32'(tick_o),    32'd0);
      check("mid_rst_busy",  32'(busy),      32'd0);
      check("mid_rst_ready", 32'(cfg_ready), 32'd1);
      check("mid_rst_err",   32'(err),       32'd0);
`ifdef CLK_DIV_CTRL_PCNT_EN
      check("mid_rst_pcnt", 32'(period_cnt), 32'd0);
      exp_pcnt = '0;
`endif
      rst = 1'b0;
      run = 1'b1;
      step();
      run_cycles("rst10", 10, 0, 2);

      // illegal ratio while running is dropped
      cfg_valid = 1'b1;
      cfg_div   = 32'd0;
      run_cycles("bad_run", 10, 2, 1);
      cfg_valid = 1'b0;
      check("bad_run_err",   32'(err),       32'd1);
      check("bad_run_ready", 32'(cfg_ready), 32'd1);
      run_cycles("after_bad", 10, 3, 17);
`ifdef CLK_DIV_CTRL_PCNT_EN
      check("pcnt_end", 32'(period_cnt), 32'(exp_pcnt));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
